digit_scanner: RTL and testbench

DIGIT_SCANNER -- requirements
Module: digit_scanner

---
 rtl/digit_scanner.sv | 129 ++++++++++++
 tb/tb_digit_scanner.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scanner.sv
// Multiplexed hex display scanner: dwells on each digit, paces an external
// one-hot phase counter via advance, and swaps in new data only at frame wrap.
module digit_scanner #(
    parameter int N     = 4,
    parameter int DWELL = 1000
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic [N-1:0]   phase,
    output logic           advance,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [4*N-1:0] load_data,
    input  logic           blank_lz,
    output logic [N-1:0]   an_n,
    output logic [6:0]     seg_n,
    output logic           phase_err
);

    localparam int CW = $clog2(DWELL);
    localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

    logic [CW-1:0]  dwellCnt;
    logic [4*N-1:0] display;
    logic [4*N-1:0] shadow;
    logic           pending;
    logic           armed;
    logic           accept;
    logic           boundary;
    logic           oneHot;
    logic [3:0]     nibble;
    logic           blankSel;
    logic           allZero;

    function automatic logic [6:0] hexSeg(input logic [3:0] v);
        case (v)
            4'h0: hexSeg = 7'b1000000;
            4'h1: hexSeg = 7'b1111001;
            4'h2: hexSeg = 7'b0100100;
            4'h3: hexSeg = 7'b0110000;
            4'h4: hexSeg = 7'b0011001;
            4'h5: hexSeg = 7'b0010010;
            4'h6: hexSeg = 7'b0000010;
            4'h7: hexSeg = 7'b1111000;
            4'h8: hexSeg = 7'b0000000;
            4'h9: hexSeg = 7'b0010000;
            4'hA: hexSeg = 7'b0001000;
            4'hB: hexSeg = 7'b0000011;
            4'hC: hexSeg = 7'b1000110;
            4'hD: hexSeg = 7'b0100001;
            4'hE: hexSeg = 7'b0000110;
            default: hexSeg = 7'b0001110;
        endcase
    endfunction

    assign advance    = (dwellCnt == LAST);
    assign load_ready = ~pending;
    assign accept     = load_valid & load_ready;
    assign boundary   = advance & phase[N-1];
    assign oneHot     = (phase != '0) && ((phase & (phase - 1'b1)) == '0);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dwellCnt <= '0;
        end else if (advance) begin
            dwellCnt <= '0;
        end else begin
            dwellCnt <= dwellCnt + 1'b1;
        end
    end

    // A load landing exactly on the wrap bypasses the shadow so it is not
    // held back a whole extra frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            display <= '0;
            shadow  <= '0;
            pending <= 1'b0;
        end else if (boundary && pending) begin
            display <= shadow;
            pending <= 1'b0;
        end else if (boundary && accept) begin
            display <= load_data;
        end else if (accept) begin
            shadow  <= load_data;
            pending <= 1'b1;
        end
    end

    // Scan from the most significant digit down so allZero covers N-1..k.
    always_comb begin
        nibble   = 4'h0;
        blankSel = 1'b0;
        allZero  = 1'b1;
        for (int k = N - 1; k >= 0; k--) begin
            allZero = allZero & (display[4*k +: 4] == 4'h0);
            if (phase[k]) begin
                nibble   = display[4*k +: 4];
                blankSel = blank_lz && (k != 0) && allZero;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            an_n  <= '1;
            seg_n <= 7'h7F;
        end else if (oneHot) begin
            an_n  <= ~phase;
            seg_n <= blankSel ? 7'h7F : hexSeg(nibble);
        end else begin
            an_n  <= '1;
            seg_n <= 7'h7F;
        end
    end

    // Checking stays disarmed until the phase source has produced one valid
    // one-hot value, so power-up garbage is not reported.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed     <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            armed     <= armed | oneHot;
            phase_err <= phase_err | (armed & ~oneHot);
        end
    end

endmodule

// File: tb/tb_digit_scanner.sv
// Directed bench for digit_scanner with N=4, DWELL=4: timing, load handshake,
// decode table, leading-zero blanking and phase error handling.
module tb_digit_scanner;

    localparam int N     = 4;
    localparam int DWELL = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [N-1:0]  phase;
    logic          advance;
    logic          load_valid = 1'b0;
    logic          load_ready;
    logic [15:0]   load_data = 16'h0;
    logic          blank_lz = 1'b0;
    logic [N-1:0]  an_n;
    logic [6:0]    seg_n;
    logic          phase_err;

    logic          useRing = 1'b0;
    logic [N-1:0]  forcedPhase = 4'b0000;
    logic [N-1:0]  ring;

    int checkCount = 0;
    int passCount  = 0;

    typedef struct {
        logic [3:0]  ph;
        logic [15:0] data;
        logic        blank;
        logic [3:0]  expAn;
        logic [6:0]  expSeg;
    } vector_t;

    vector_t vecs[$];

    digit_scanner #(.N(N), .DWELL(DWELL)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .phase      (phase),
        .advance    (advance),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .blank_lz   (blank_lz),
        .an_n       (an_n),
        .seg_n      (seg_n),
        .phase_err  (phase_err)
    );

    always #5 clk = ~clk;

    // Stand-in for the upstream phase counter, enabled by advance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ring <= 4'b0001;
        end else if (advance) begin
            ring <= {ring[2:0], ring[3]};
        end
    end

    assign phase = useRing ? ring : forcedPhase;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic waitReady(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (load_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput({name, "_timeout"}, 16'(load_ready), 16'h1);
    endtask

    task automatic waitDigit(input int k, input string name);
        bit ok = 1'b0;
        logic [3:0] want;
        want = ~(4'b0001 << k);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an_n == want) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput({name, "_timeout"}, 16'(an_n), 16'(want));
    endtask

    task automatic waitAdvance(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (advance) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) checkOutput({name, "_timeout"}, 16'(advance), 16'h1);
    endtask

    task automatic pulseReset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic addVec(input logic [3:0] ph, input logic [15:0] data, input logic blank,
                          input logic [3:0] expAn, input logic [6:0] expSeg);
        vector_t v;
        v.ph = ph; v.data = data; v.blank = blank; v.expAn = expAn; v.expSeg = expSeg;
        vecs.push_back(v);
    endtask

    // Loads are pushed through with phase parked on the last digit so every
    // advance is a frame boundary, then the vector's phase is presented.
    task automatic applyStimulus(input vector_t v, input int idx);
        string nm;
        nm = $sformatf("vec%0d", idx);
        forcedPhase = 4'b1000;
        waitReady(nm);
        load_valid = 1'b1;
        load_data  = v.data;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        waitReady(nm);
        forcedPhase = v.ph;
        blank_lz    = v.blank;
        @(posedge clk);
        @(negedge clk);
        checkOutput({nm, "_an"}, 16'(an_n), 16'(v.expAn));
        checkOutput({nm, "_seg"}, 16'(seg_n), 16'(v.expSeg));
    endtask

    initial begin
        // Reset values and advance cadence with a dead phase source.
        repeat (2) @(negedge clk);
        checkOutput("rst_an", 16'(an_n), 16'hF);
        checkOutput("rst_seg", 16'(seg_n), 16'h7F);
        checkOutput("rst_ready", 16'(load_ready), 16'h1);
        checkOutput("rst_err", 16'(phase_err), 16'h0);
        checkOutput("rst_adv", 16'(advance), 16'h0);
        reset_n = 1'b1;
        #1;
        checkOutput("adv_c1", 16'(advance), 16'h0);
        for (int c = 2; c <= 12; c++) begin
            @(negedge clk);
            checkOutput($sformatf("adv_c%0d", c), 16'(advance), 16'((c % 4) == 0));
        end
        checkOutput("zero_an", 16'(an_n), 16'hF);
        checkOutput("zero_err", 16'(phase_err), 16'h0);

        forcedPhase = 4'b0001;
        @(posedge clk);
        @(negedge clk);
        checkOutput("arm_an", 16'(an_n), 16'hE);
        checkOutput("arm_err", 16'(phase_err), 16'h0);
        forcedPhase = 4'b0011;
        @(posedge clk);
        @(negedge clk);
        checkOutput("bad_err", 16'(phase_err), 16'h1);
        checkOutput("bad_an", 16'(an_n), 16'hF);
        checkOutput("bad_seg", 16'(seg_n), 16'h7F);
        forcedPhase = 4'b0001;
        repeat (3) @(negedge clk);
        checkOutput("sticky_err", 16'(phase_err), 16'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("clr_err", 16'(phase_err), 16'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Load 0x1F80 through the shadow; nibble k drives digit k.
        pulseReset();
        useRing = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1F80;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        checkOutput("ld_pending", 16'(load_ready), 16'h0);
        waitReady("ld_wait");
        waitDigit(0, "d0");
        checkOutput("d0_seg", 16'(seg_n), 16'h40);
        waitDigit(1, "d1");
        checkOutput("d1_seg", 16'(seg_n), 16'h00);
        waitDigit(2, "d2");
        checkOutput("d2_seg", 16'(seg_n), 16'h0E);
        waitDigit(3, "d3");
        checkOutput("d3_seg", 16'(seg_n), 16'h79);

        // Back-to-back loads with load_valid held.
        waitDigit(1, "b2b_sync");
        load_valid = 1'b1;
        load_data  = 16'h0008;
        @(posedge clk);
        @(negedge clk);
        checkOutput("b2b_stall", 16'(load_ready), 16'h0);
        load_data = 16'h0001;
        waitReady("b2b_first");
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        checkOutput("b2b_second_acc", 16'(load_ready), 16'h0);
        waitDigit(0, "b2b_d0a");
        checkOutput("b2b_frame1", 16'(seg_n), 16'h00);
        waitReady("b2b_second");
        waitDigit(0, "b2b_d0b");
        checkOutput("b2b_frame2", 16'(seg_n), 16'h79);

        // Load on a boundary cycle with nothing pending goes straight to display.
        pulseReset();
        useRing = 1'b0;
        forcedPhase = 4'b1000;
        waitAdvance("bnd");
        load_valid = 1'b1;
        load_data  = 16'h7000;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        checkOutput("bnd_ready", 16'(load_ready), 16'h1);
        checkOutput("bnd_seg_old", 16'(seg_n), 16'h40);
        @(posedge clk);
        @(negedge clk);
        checkOutput("bnd_seg_new", 16'(seg_n), 16'h78);
        checkOutput("bnd_an", 16'(an_n), 16'h7);

        // Reset with a load pending discards it.
        load_valid = 1'b1;
        load_data  = 16'h3000;
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
        checkOutput("mid_pending", 16'(load_ready), 16'h0);
        reset_n = 1'b0;
        #1;
        checkOutput("mid_ready", 16'(load_ready), 16'h1);
        checkOutput("mid_an", 16'(an_n), 16'hF);
        checkOutput("mid_seg", 16'(seg_n), 16'h7F);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3 * DWELL) @(negedge clk);
        checkOutput("mid_discard_an", 16'(an_n), 16'h7);
        checkOutput("mid_discard_seg", 16'(seg_n), 16'h40);

        // Decode and blanking table.
        addVec(4'b0001, 16'h0000, 1'b0, 4'hE, 7'b1000000);
        addVec(4'b0001, 16'h0001, 1'b0, 4'hE, 7'b1111001);
        addVec(4'b0001, 16'h0002, 1'b0, 4'hE, 7'b0100100);
        addVec(4'b0001, 16'h0003, 1'b0, 4'hE, 7'b0110000);
        addVec(4'b0001, 16'h0004, 1'b0, 4'hE, 7'b0011001);
        addVec(4'b0001, 16'h0005, 1'b0, 4'hE, 7'b0010010);
        addVec(4'b0001, 16'h0006, 1'b0, 4'hE, 7'b0000010);
        addVec(4'b0001, 16'h0007, 1'b0, 4'hE, 7'b1111000);
        addVec(4'b0001, 16'h0008, 1'b0, 4'hE, 7'b0000000);
        addVec(4'b0001, 16'h0009, 1'b0, 4'hE, 7'b0010000);
        addVec(4'b0001, 16'h000A, 1'b0, 4'hE, 7'b0001000);
        addVec(4'b0001, 16'h000B, 1'b0, 4'hE, 7'b0000011);
        addVec(4'b0001, 16'h000C, 1'b0, 4'hE, 7'b1000110);
        addVec(4'b0001, 16'h000D, 1'b0, 4'hE, 7'b0100001);
        addVec(4'b0001, 16'h000E, 1'b0, 4'hE, 7'b0000110);
        addVec(4'b0001, 16'h000F, 1'b0, 4'hE, 7'b0001110);
        addVec(4'b1000, 16'h0005, 1'b1, 4'h7, 7'h7F);
        addVec(4'b0100, 16'h0005, 1'b1, 4'hB, 7'h7F);
        addVec(4'b0010, 16'h0005, 1'b1, 4'hD, 7'h7F);
        addVec(4'b0001, 16'h0005, 1'b1, 4'hE, 7'b0010010);
        addVec(4'b0001, 16'h0000, 1'b1, 4'hE, 7'b1000000);
        addVec(4'b0010, 16'h0000, 1'b1, 4'hD, 7'h7F);
        addVec(4'b0010, 16'h0050, 1'b1, 4'hD, 7'b0010010);
        addVec(4'b1000, 16'h0050, 1'b1, 4'h7, 7'h7F);
        addVec(4'b0100, 16'h0A00, 1'b1, 4'hB, 7'b0001000);
        addVec(4'b1000, 16'h0A00, 1'b1, 4'h7, 7'h7F);
        addVec(4'b1000, 16'h0005, 1'b0, 4'h7, 7'b1000000);
        foreach (vecs[i]) applyStimulus(vecs[i], i);
        checkOutput("table_err", 16'(phase_err), 16'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
